// File: rtl/riscv_pkg.sv
// Shared definitions for the M-extension multiply/divide unit: funct3 opcodes,
// FSM state encodings and a constant clog2 helper for tag widths.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

  function automatic int clog2(input int value);
    int r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring-division iterator on unsigned magnitudes; exposes the next
// quotient/remainder so the controller can capture the final step directly.
module div_core #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quot_nxt,
  output logic [N-1:0] o_rem_nxt
);

  logic [N-1:0] r_quot;
  logic [N-1:0] r_rem;
  logic [N-1:0] r_dvsr;
  logic [N:0]   w_shift;
  logic [N:0]   w_diff;

  // r_quot doubles as the dividend shift register; quotient bits enter at the bottom
  assign w_shift    = {r_rem, r_quot[N-1]};
  assign w_diff     = w_shift - {1'b0, r_dvsr};
  assign o_rem_nxt  = w_diff[N] ? w_shift[N-1:0] : w_diff[N-1:0];
  assign o_quot_nxt = {r_quot[N-2:0], ~w_diff[N]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_dvsr <= '0;
    end else if (i_load) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_dvsr <= i_divisor;
    end else if (i_step) begin
      r_quot <= o_quot_nxt;
      r_rem  <= o_rem_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with register-file tagging.
// Define MULDIV_DIV_EN to build the divide path; otherwise divide ops report ILLEGAL.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int N    = 32,
  parameter int XLEN = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [2:0]               i_op,
  input  logic [N-1:0]             i_a,
  input  logic [N-1:0]             i_b,
  input  logic [clog2(XLEN)-1:0]   i_rd_in,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [N-1:0]             o_res,
  output logic [clog2(XLEN)-1:0]   o_rd_out,
  output logic                     o_illegal
);

  localparam int RW = clog2(XLEN);
  localparam int CW = (clog2(N) > 0) ? clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e         r_state;
  logic [2:0]     r_op;
  logic [RW-1:0]  r_rd;
  logic [N-1:0]   r_ma;
  logic [2*N-1:0] r_prod;
  logic [CW-1:0]  r_cnt;
  logic           r_neg;

  logic           w_accept;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [N-1:0]   w_a_mag;
  logic [N-1:0]   w_b_mag;
  logic [N:0]     w_sum;
  logic [2*N-1:0] w_prod_nxt;
  logic [2*N-1:0] w_prod_fin;
  logic [N-1:0]   w_mul_res;

  assign w_accept = i_start && (r_state == ST_IDLE || r_state == ST_FIN);

  always_comb begin
    w_a_neg = 1'b0;
    w_b_neg = 1'b0;
    case (i_op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_a_neg = i_a[N-1];
        w_b_neg = i_b[N-1];
      end
      OP_MULHSU: w_a_neg = i_a[N-1];
      default: ;
    endcase
  end

  assign w_a_mag = w_a_neg ? -i_a : i_a;
  assign w_b_mag = w_b_neg ? -i_b : i_b;

  // Shift-add: multiplier sits in the low half and is consumed one bit per step
  assign w_sum      = {1'b0, r_prod[2*N-1:N]} + (r_prod[0] ? {1'b0, r_ma} : '0);
  assign w_prod_nxt = {w_sum, r_prod[N-1:1]};
  assign w_prod_fin = r_neg ? -w_prod_nxt : w_prod_nxt;
  assign w_mul_res  = (r_op == OP_MUL) ? w_prod_fin[N-1:0] : w_prod_fin[2*N-1:N];

`ifdef MULDIV_DIV_EN
  logic         r_neg_r;
  logic         w_b_zero;
  logic         w_ovf;
  logic [N-1:0] w_byp_res;
  logic [N-1:0] w_quot_nxt;
  logic [N-1:0] w_rem_nxt;
  logic [N-1:0] w_div_res;

  assign w_b_zero  = (i_b == '0);
  assign w_ovf     = (i_op == OP_DIV || i_op == OP_REM) &&
                     (i_a == {1'b1, {(N-1){1'b0}}}) && (i_b == '1);
  assign w_byp_res = w_ovf ? (i_op[1] ? '0 : i_a) : (i_op[1] ? i_a : '1);
  assign w_div_res = r_op[1] ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                             : (r_neg ? -w_quot_nxt : w_quot_nxt);

  div_core #(.N(N)) u_div_core (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_accept && i_op[2]),
    .i_step     (r_state == ST_DIV),
    .i_dividend (w_a_mag),
    .i_divisor  (w_b_mag),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_rd      <= '0;
      r_ma      <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_illegal <= 1'b0;
      o_res     <= '0;
      o_rd_out  <= '0;
`ifdef MULDIV_DIV_EN
      r_neg_r   <= 1'b0;
`endif
    end else begin
      o_done    <= 1'b0;
      o_illegal <= 1'b0;
      case (r_state)
        ST_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state  <= ST_FIN;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_res    <= w_mul_res;
            o_rd_out <= r_rd;
          end
        end
        ST_DIV: begin
`ifdef MULDIV_DIV_EN
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state  <= ST_FIN;
            o_busy   <= 1'b0;
            o_done   <= 1'b1;
            o_res    <= w_div_res;
            o_rd_out <= r_rd;
          end
`else
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
`endif
        end
        ST_IDLE, ST_FIN: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
          if (w_accept) begin
            r_op  <= i_op;
            r_rd  <= i_rd_in;
            r_cnt <= CNT_LAST;
            r_neg <= w_a_neg ^ w_b_neg;
            if (!i_op[2]) begin
              r_ma    <= w_a_mag;
              r_prod  <= {{N{1'b0}}, w_b_mag};
              r_state <= ST_MUL;
              o_busy  <= 1'b1;
            end else begin
`ifdef MULDIV_DIV_EN
              r_neg_r <= w_a_neg;
              if (w_b_zero || w_ovf) begin
                r_state  <= ST_FIN;
                o_done   <= 1'b1;
                o_res    <= w_byp_res;
                o_rd_out <= i_rd_in;
              end else begin
                r_state <= ST_DIV;
                o_busy  <= 1'b1;
              end
`else
              r_state   <= ST_FIN;
              o_done    <= 1'b1;
              o_illegal <= 1'b1;
              o_res     <= '0;
              o_rd_out  <= i_rd_in;
`endif
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops against
// an arithmetic reference model, busy-ignore, FIN hold, back-to-back and reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, illegal;
  logic [31:0] res;
  logic [4:0]  rd_out;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.N(32), .XLEN(32)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_start   (start),
    .i_op      (op),
    .i_a       (a),
    .i_b       (b),
    .i_rd_in   (rd_in),
    .o_busy    (busy),
    .o_done    (done),
    .o_res     (res),
    .o_rd_out  (rd_out),
    .o_illegal (illegal)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic plus the architectural corner cases
  function automatic logic [31:0] ref_res(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    longint          sa = $signed(t_a);
    longint          sb = $signed(t_b);
    longint unsigned ua = t_a;
    longint unsigned ub = t_b;
    logic [63:0]     p;
    logic [31:0]     q;
    case (t_op)
      3'd0: begin p = ua * ub; q = p[31:0]; end
      3'd1: begin p = sa * sb; q = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); q = p[63:32]; end
      3'd3: begin p = ua * ub; q = p[63:32]; end
      default: begin
`ifdef MULDIV_DIV_EN
        if (t_b == 32'd0) q = t_op[1] ? t_a : 32'hFFFF_FFFF;
        else if (!t_op[0] && t_a == 32'h8000_0000 && t_b == 32'hFFFF_FFFF) q = t_op[1] ? 32'd0 : t_a;
        else if (!t_op[0]) q = t_op[1] ? 32'(sa % sb) : 32'(sa / sb);
        else q = t_op[1] ? (t_a % t_b) : (t_a / t_b);
`else
        q = 32'd0;
`endif
      end
    endcase
    return q;
  endfunction

  function automatic int ref_lat(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
    if (!t_op[2]) return 33;
`ifdef MULDIV_DIV_EN
    if (t_b == 32'd0) return 1;
    if (!t_op[0] && t_a == 32'h8000_0000 && t_b == 32'hFFFF_FFFF) return 1;
    return 33;
`else
    return 1;
`endif
  endfunction

  function automatic logic ref_ill(input logic [2:0] t_op);
`ifdef MULDIV_DIV_EN
    return 1'b0;
`else
    return t_op[2];
`endif
  endfunction

  // Issues one operation and waits (bounded) for DONE; leaves the DUT in FIN
  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        input logic [4:0] t_rd, output logic [31:0] t_res, output logic t_ill,
                        output logic [4:0] t_rdo, output int t_cyc, output logic t_busy1);
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b; rd_in = t_rd;
    @(posedge clk); #1;
    start = 1'b0;
    t_cyc = 1;
    t_busy1 = busy;
    while (done !== 1'b1 && t_cyc < 200) begin
      @(posedge clk); #1;
      t_cyc++;
    end
    t_res = res; t_ill = illegal; t_rdo = rd_out;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++; if (res !== 32'd0)    begin errors++; $display("FAIL reset_res got %h exp 0", res); end
    checks++; if (rd_out !== 5'd0)  begin errors++; $display("FAIL reset_rd got %0d exp 0", rd_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [7:0]  lat;
    } vec_t;
    vec_t        v[9];
    logic [31:0] r_exp, got;
    int          lat_exp, cyc;
    logic        ill, ill_exp, b1;
    logic [4:0]  rdo, rd;
    v[0] = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd33};
    v[1] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33};
    v[2] = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 8'd33};
    v[3] = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 8'd33};
    v[4] = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 8'd33};
    v[5] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1};
    v[6] = '{3'd7, 32'd5,          32'd0,         32'd5,         8'd1};
    v[7] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
    v[8] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         8'd1};
    for (int i = 0; i < 9; i++) begin
      r_exp = v[i].res; lat_exp = int'(v[i].lat); ill_exp = 1'b0;
`ifndef MULDIV_DIV_EN
      if (v[i].op[2]) begin r_exp = 32'd0; lat_exp = 1; ill_exp = 1'b1; end
`endif
      rd = 5'(i + 1);
      run_op(v[i].op, v[i].a, v[i].b, rd, got, ill, rdo, cyc, b1);
      checks++; if (got !== r_exp)  begin errors++; $display("FAIL dir_res[%0d] got %h exp %h", i, got, r_exp); end
      checks++; if (cyc != lat_exp) begin errors++; $display("FAIL dir_lat[%0d] got %0d exp %0d", i, cyc, lat_exp); end
      checks++; if (ill !== ill_exp) begin errors++; $display("FAIL dir_ill[%0d] got %b exp %b", i, ill, ill_exp); end
      checks++; if (rdo !== rd)     begin errors++; $display("FAIL dir_rd[%0d] got %0d exp %0d", i, rdo, rd); end
      checks++; if (b1 !== (lat_exp > 1)) begin errors++; $display("FAIL dir_busy[%0d] got %b exp %b", i, b1, lat_exp > 1); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y, got, r_exp;
    logic [4:0]  rd, rdo;
    logic        ill, b1;
    int          cyc, lat_exp;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 6))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: x = 32'h8000_0000;
        3: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      rd = 5'($urandom);
      r_exp = ref_res(o, x, y);
      lat_exp = ref_lat(o, x, y);
      run_op(o, x, y, rd, got, ill, rdo, cyc, b1);
      checks++; if (got !== r_exp)  begin errors++; $display("FAIL rand_res op=%0d a=%h b=%h got %h exp %h", o, x, y, got, r_exp); end
      checks++; if (cyc != lat_exp) begin errors++; $display("FAIL rand_lat op=%0d got %0d exp %0d", o, cyc, lat_exp); end
      checks++; if (ill !== ref_ill(o)) begin errors++; $display("FAIL rand_ill op=%0d got %b exp %b", o, ill, ref_ill(o)); end
      checks++; if (rdo !== rd)     begin errors++; $display("FAIL rand_rd got %0d exp %0d", rdo, rd); end
    end
  endtask

  task automatic test_fin_hold();
    logic [31:0] got, r_exp;
    logic [4:0]  rdo;
    logic        ill, b1;
    int          cyc;
    r_exp = ref_res(3'd0, 32'd12345, 32'd678);
    run_op(3'd0, 32'd12345, 32'd678, 5'd0, got, ill, rdo, cyc, b1);
    checks++; if (got !== r_exp) begin errors++; $display("FAIL x0_res got %h exp %h", got, r_exp); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL hold_done got %b exp 0", done); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL hold_busy got %b exp 0", busy); end
    checks++; if (res !== r_exp)  begin errors++; $display("FAIL hold_res got %h exp %h", res, r_exp); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL hold_rd got %0d exp 0", rd_out); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] x, y, r_exp;
    int          cyc;
    x = $urandom; y = $urandom;
    r_exp = ref_res(3'd2, x, y);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = x; b = y; rd_in = 5'd3;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; op = 3'd3; a = $urandom; b = $urandom; rd_in = 5'd17;
    repeat (3) begin
      @(posedge clk); #1; cyc++;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy cyc=%0d got %b exp 1", cyc, busy); end
    end
    start = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    checks++; if (cyc != 33)      begin errors++; $display("FAIL ign_lat got %0d exp 33", cyc); end
    checks++; if (res !== r_exp)  begin errors++; $display("FAIL ign_res got %h exp %h", res, r_exp); end
    checks++; if (rd_out !== 5'd3) begin errors++; $display("FAIL ign_rd got %0d exp 3", rd_out); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, r_exp;
    logic [4:0]  rdo;
    logic        ill, b1;
    int          cyc;
    // run_op starts in the FIN cycle of the previous op, so the accept is from FIN
    for (int i = 0; i < 3; i++) begin
      r_exp = ref_res(3'd1, 32'hFFFF_0000 + 32'(i), 32'd1000 + 32'(i));
      run_op(3'd1, 32'hFFFF_0000 + 32'(i), 32'd1000 + 32'(i), 5'(20 + i), got, ill, rdo, cyc, b1);
      checks++; if (got !== r_exp) begin errors++; $display("FAIL b2b_res[%0d] got %h exp %h", i, got, r_exp); end
      checks++; if (cyc != 33)     begin errors++; $display("FAIL b2b_lat[%0d] got %0d exp 33", i, cyc); end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse got %b exp 0", done); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] got;
    logic [4:0]  rdo;
    logic        ill, b1, seen;
    int          cyc;
    run_op(3'd0, 32'd3, 32'd5, 5'd9, got, ill, rdo, cyc, b1);
    checks++; if (got !== 32'd15) begin errors++; $display("FAIL pre_res got %h exp 0000000f", got); end
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd11; b = 32'd13; rd_in = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL abort_done got %b exp 0", done); end
    checks++; if (res !== 32'd0)    begin errors++; $display("FAIL abort_res got %h exp 0", res); end
    checks++; if (rd_out !== 5'd0)  begin errors++; $display("FAIL abort_rd got %0d exp 0", rd_out); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL abort_ill got %b exp 0", illegal); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_nodone got %b exp 0", seen); end
    run_op(3'd0, 32'd11, 32'd13, 5'd7, got, ill, rdo, cyc, b1);
    checks++; if (got !== 32'd143) begin errors++; $display("FAIL post_res got %h exp 0000008f", got); end
    checks++; if (cyc != 33)       begin errors++; $display("FAIL post_lat got %0d exp 33", cyc); end
    checks++; if (rdo !== 5'd7)    begin errors++; $display("FAIL post_rd got %0d exp 7", rdo); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_fin_hold();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
